dcache_req_arbiter: RTL

Shares the single HPDC core request port among NREQ requesters (load/store unit, page-table walker, vector memory unit) sitting in front of the dcache interface. Round-robin arbitration with grant lock across back-pressure, requester ID carried in the HPDC `sid` field, and response routing back by `sid`. Per-requester outstanding-request counters cap in-flight traffic and provide a drain/idle indication for fences.

---
 rtl/dcache_req_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter sharing the HPDC request port among NREQ requesters,
// with grant lock under back-pressure and sid-based response routing.
module dcache_req_arbiter #(
   parameter int NREQ    = 2,
   parameter int REQ_W   = 128,
   parameter int RSP_W   = 72,
   parameter int MAX_OUT = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NREQ-1:0]       req_valid_i,
   output logic [NREQ-1:0]       req_ready_o,
   input  logic [NREQ-1:0]       req_need_rsp_i,
   input  logic [NREQ*REQ_W-1:0] req_payload_i,
   output logic                  dcache_req_valid_o,
   input  logic                  dcache_req_ready_i,
   output logic [REQ_W-1:0]      dcache_req_payload_o,
   output logic [2:0]            dcache_req_sid_o,
   output logic                  dcache_req_need_rsp_o,
   input  logic                  dcache_rsp_valid_i,
   input  logic [2:0]            dcache_rsp_sid_i,
   input  logic [RSP_W-1:0]      dcache_rsp_payload_i,
   output logic [NREQ-1:0]       rsp_valid_o,
   output logic [RSP_W-1:0]      rsp_payload_o,
   output logic [NREQ*4-1:0]     outstanding_o,
   output logic                  idle_o,
   output logic                  err_o
);

   localparam logic [3:0] N4   = 4'(NREQ);
   localparam logic [3:0] MAXC = 4'(MAX_OUT);

   typedef enum logic {ST_ARB, ST_LOCK} state_e;

   state_e          state_q, state_d;
   logic [2:0]      rr_q, rr_d;
   logic [2:0]      lock_q, lock_d;
   logic [3:0]      cnt_q [NREQ];
   logic [3:0]      cnt_d [NREQ];
   logic            err_q, err_d;

   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] rsp_hit;
   logic [2:0]      arb_idx, grant;
   logic            arb_found, gvalid, accept;
   logic            drop_err, rsp_err;

   function automatic logic [2:0] wrap(input logic [3:0] v);
      return (v >= N4) ? 3'(v - N4) : v[2:0];
   endfunction

   // Eligibility uses registered counts only; a same-cycle response
   // frees a slot for the following cycle.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NREQ; i++) begin
         elig[i] = req_valid_i[i] && (cnt_q[i] < MAXC);
      end
   end

   always_comb begin
      arb_found = 1'b0;
      arb_idx   = rr_q;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!arb_found && elig[i] &&
                3'(i) == wrap({1'b0, rr_q} + 4'(k))) begin
               arb_found = 1'b1;
               arb_idx   = 3'(i);
            end
         end
      end
   end

   always_comb begin
      grant  = arb_idx;
      gvalid = arb_found;
      if (state_q == ST_LOCK) begin
         grant  = lock_q;
         gvalid = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == lock_q) gvalid = req_valid_i[i];
         end
      end
   end

   assign accept             = gvalid && dcache_req_ready_i;
   assign dcache_req_valid_o = gvalid;
   assign dcache_req_sid_o   = grant + 3'd1;

   always_comb begin
      dcache_req_payload_o  = '0;
      dcache_req_need_rsp_o = 1'b0;
      req_ready_o           = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (3'(i) == grant) begin
            dcache_req_payload_o  = req_payload_i[i*REQ_W +: REQ_W];
            dcache_req_need_rsp_o = req_need_rsp_i[i];
            req_ready_o[i]        = accept;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      lock_d   = lock_q;
      drop_err = 1'b0;
      unique case (state_q)
         ST_ARB: begin
            if (gvalid && !dcache_req_ready_i) begin
               state_d = ST_LOCK;
               lock_d  = grant;
            end
         end
         ST_LOCK: begin
            if (!gvalid) begin
               state_d  = ST_ARB;
               drop_err = 1'b1;
            end else if (dcache_req_ready_i) begin
               state_d = ST_ARB;
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   assign rr_d = accept ? wrap({1'b0, grant} + 4'd1) : rr_q;

   always_comb begin
      rsp_hit = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_hit[i] = dcache_rsp_valid_i &&
                      (dcache_rsp_sid_i == 3'(i + 1)) &&
                      (cnt_q[i] != 4'd0);
      end
   end

   assign rsp_valid_o   = rsp_hit;
   assign rsp_payload_o = dcache_rsp_payload_i;
   assign rsp_err       = dcache_rsp_valid_i && !(|rsp_hit);
   assign err_d         = err_q | rsp_err | drop_err;
   assign err_o         = err_q;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         cnt_d[i] = cnt_q[i]
                  + {3'b0, accept && dcache_req_need_rsp_o && (grant == 3'(i))}
                  - {3'b0, rsp_hit[i]};
      end
   end

   always_comb begin
      outstanding_o = '0;
      idle_o        = !gvalid;
      for (int i = 0; i < NREQ; i++) begin
         outstanding_o[i*4 +: 4] = cnt_q[i];
         if (cnt_q[i] != 4'd0) idle_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_ARB;
         rr_q    <= '0;
         lock_q  <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         lock_q  <= lock_d;
         err_q   <= err_d;
         for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
      end
   end

endmodule
